vram_console: RTL
=================

# vram_console

Character-stream front end for VRAM port A: it turns a byte stream (CPU or boot source) into text-mode VRAM writes. It keeps a cursor over a COLS×ROWS cell grid and interprets a small set of control codes. It clears a row when the cursor enters it, and clears the whole screen after reset or on request. The LCD reader consumes the VRAM it fills through port B and the 8×16 font ROM; the 480×272 panel gives a 60×17 grid.

## Interface
- COLS, default 60: cells per row.
- ROWS, default 17: rows per screen. Constraint: COLS*ROWS ≤ 2^ADDR_W.
- ADDR_W, default 10: VRAM address width.
- BLANK, default 8'h20: fill byte used for clears and backspace.
- MEMORY_CLK  in  1  clock; all logic on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  in_char is offered.
- in_char  in  8  character or control byte.
- in_ready  out  1  byte accepted at an edge where in_valid & in_ready.
- clear_req  in  1  single-cycle pulse requesting a full-screen clear.
- v_ada  out  ADDR_W  VRAM port-A address.
- v_din  out  8  VRAM port-A write data.
- v_cea  out  1  VRAM port-A write enable; one byte is written per cycle it is high.
- cursor_col  out  6  current column, 0..COLS-1.
- cursor_row  out  5  current row, 0..ROWS-1.
- busy  out  1  high whenever state ≠ IDLE.

## Operation
- States:
  - CLEAR: writes BLANK to addresses 0..COLS*ROWS-1.
  - IDLE: waits for input.
  - WRITE: performs one cell write.
  - CLRROW: writes BLANK to the COLS cells of cursor_row.
- in_ready = (state==IDLE) & !clear_pending. It is combinational from registers and never depends on in_valid.
- Byte handling on acceptance in IDLE:
  - 0x0D (CR): col←0. No write; stays in IDLE.
  - 0x0A (LF): col←0 and the row advances; goes to CLRROW.
  - 0x08 (BS): if col>0, col←col-1, then WRITE BLANK at the new cell. If col==0, no-op.
  - 0x0C (FF): col←0, row←0; goes to CLEAR.
  - Any other byte, including 0x00–0x1F and 0x80–0xFF: WRITE the byte at row*COLS+col, then col advances.
- Column advance: when col==COLS-1, col←0 and the row advances. On a row advance, WRITE is followed by CLRROW.
- Row advance: row←(row==ROWS-1) ? 0 : row+1. There is no scrolling; the destination row is always cleared.
- clear_req: a pulse is latched into clear_pending in any state and is serviced when the block next reaches IDLE.
  - Servicing means: go to CLEAR, set the cursor to (0,0), and drop clear_pending.
  - clear_pending outranks in_valid in the same cycle.
  - Several pulses before servicing produce one clear.
- Address arithmetic: row*COLS+col is computed at ADDR_W width and never exceeds COLS*ROWS-1. Addresses COLS*ROWS..2^ADDR_W-1 are never written.

## Timing
- Reset values:
  - state: CLEAR.
  - v_ada: 0, v_din: BLANK, v_cea: 0.
  - cursor: (0,0).
  - clear_pending: 0.
  - busy: 1, in_ready: 0.
- CLEAR:
  - Starts at the first edge after reset release.
  - v_cea=1 for exactly COLS*ROWS consecutive cycles; v_ada steps 0,1,… once per cycle with v_din=BLANK.
  - At the edge after the last address: IDLE, v_cea←0.
- Printable byte accepted at edge N:
  - Edge N+1: v_cea=1, v_ada=cell address, v_din=byte. The cursor is updated at edge N.
  - Edge N+2: return to IDLE with v_cea=0, or start CLRROW.
  - Throughput: one byte per 2 cycles.
- CLRROW:
  - v_cea=1 for COLS cycles; v_ada runs from row_base to row_base+COLS-1; v_din=BLANK.
  - Then IDLE.
  - An LF accepted at edge N gives its first clear write at edge N+1.
- CR and no-op BS consume one accept cycle with no VRAM traffic; in_ready stays high.
- All outputs are registered, except in_ready, which is derived from registered state only.
- Reset asserted mid-operation aborts immediately: outputs return to reset values and the CLEAR sequence restarts from address 0 after release.

## Test plan
- Reset release: 1020 consecutive v_cea cycles, addresses 0..1019, v_din=0x20. Then in_ready=1, busy=0, cursor (0,0). Address 1020 is never driven.
- Send 'A' (0x41) at (0,0): one v_cea cycle with v_ada=0, v_din=0x41. Cursor becomes (1,0). in_ready is low for exactly 1 cycle.
- Send 60 bytes 0x30.. from (0,0):
  - Last write is at v_ada=59.
  - CLRROW then writes 60..119 with 0x20.
  - Cursor (0,1); in_ready is low for the 60 clear cycles.
- Wrap: cursor at (59,16), send 0x5A. Expect a write at 1019, then a clear of 0..59, then cursor (0,0).
- Controls at (5,3):
  - BS: writes 0x20 at 184; cursor (4,3).
  - CR: cursor (0,3), no write.
  - BS at col 0: no write.
  - LF: clears 240..299; cursor (0,4).
  - FF: full CLEAR; cursor (0,0).
- Clear request and reset:
  - clear_req pulsed twice during CLRROW: after CLRROW ends, exactly one full CLEAR.
  - clear_req and in_valid in the same IDLE cycle: the byte is not accepted.
  - rst_n asserted at CLEAR address 500: after release, CLEAR restarts at address 0.

Source files
------------

// File: rtl/vram_console.sv
// Character-stream front end for VRAM port A: turns a byte stream into text-mode
// cell writes, tracks a cursor over a COLS x ROWS grid and interprets CR/LF/BS/FF.
module vram_console #(
   parameter int          COLS   = 60,
   parameter int          ROWS   = 17,
   parameter int          ADDR_W = 10,
   parameter logic [7:0]  BLANK  = 8'h20
) (
   input  logic              MEMORY_CLK,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [7:0]        in_char,
   output logic              in_ready,
   input  logic              clear_req,
   output logic [ADDR_W-1:0] v_ada,
   output logic [7:0]        v_din,
   output logic              v_cea,
   output logic [5:0]        cursor_col,
   output logic [4:0]        cursor_row,
   output logic              busy
);

   typedef enum logic [1:0] {CLEAR, IDLE, WRITE, CLRROW} state_t;

   localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(COLS * ROWS - 1);
   localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(COLS - 1);
   localparam logic [5:0]        LAST_COL  = 6'(COLS - 1);
   localparam logic [4:0]        LAST_ROW  = 5'(ROWS - 1);

   state_t              state, state_d;
   logic [ADDR_W-1:0]   ptr, ptr_d;
   logic [ADDR_W-1:0]   wr_addr, wr_addr_d;
   logic [7:0]          wr_data, wr_data_d;
   logic                wr_clr, wr_clr_d;
   logic                clear_pending, clear_pending_d;
   logic [5:0]          col_d;
   logic [4:0]          row_d;
   logic [ADDR_W-1:0]   v_ada_d;
   logic [7:0]          v_din_d;
   logic                v_cea_d;

   logic [ADDR_W-1:0]   row_base;
   logic [ADDR_W-1:0]   cell_addr;
   logic [4:0]          row_next;

   assign row_base  = ADDR_W'(cursor_row) * ADDR_W'(COLS);
   assign cell_addr = row_base + ADDR_W'(cursor_col);
   assign row_next  = (cursor_row == LAST_ROW) ? 5'd0 : cursor_row + 5'd1;
   assign in_ready  = (state == IDLE) && !clear_pending;

   always_comb begin
      // NOTE: every value written here gets a default first, so no latch is inferred.
      state_d         = state;
      ptr_d           = ptr;
      wr_addr_d       = wr_addr;
      wr_data_d       = wr_data;
      wr_clr_d        = wr_clr;
      clear_pending_d = clear_pending | clear_req;
      col_d           = cursor_col;
      row_d           = cursor_row;
      v_ada_d         = v_ada;
      v_din_d         = v_din;
      v_cea_d         = 1'b0;

      case (state)
         CLEAR: begin
            v_cea_d = 1'b1;
            v_ada_d = ptr;
            v_din_d = BLANK;
            ptr_d   = ptr + ADDR_W'(1);
            if (ptr == LAST_CELL) state_d = IDLE;
         end

         IDLE: begin
            // A clear request seen on this edge wins over a byte offered on the same edge.
            if (clear_pending || clear_req) begin
               state_d         = CLEAR;
               ptr_d           = '0;
               col_d           = '0;
               row_d           = '0;
               clear_pending_d = 1'b0;
            end else if (in_valid) begin
               case (in_char)
                  8'h0D: col_d = '0;
                  8'h0A: begin
                     col_d   = '0;
                     row_d   = row_next;
                     ptr_d   = '0;
                     state_d = CLRROW;
                  end
                  8'h08: begin
                     if (cursor_col != 6'd0) begin
                        col_d     = cursor_col - 6'd1;
                        wr_addr_d = cell_addr - ADDR_W'(1);
                        wr_data_d = BLANK;
                        wr_clr_d  = 1'b0;
                        state_d   = WRITE;
                     end
                  end
                  8'h0C: begin
                     col_d   = '0;
                     row_d   = '0;
                     ptr_d   = '0;
                     state_d = CLEAR;
                  end
                  default: begin
                     wr_addr_d = cell_addr;
                     wr_data_d = in_char;
                     state_d   = WRITE;
                     if (cursor_col == LAST_COL) begin
                        col_d    = '0;
                        row_d    = row_next;
                        wr_clr_d = 1'b1;
                     end else begin
                        col_d    = cursor_col + 6'd1;
                        wr_clr_d = 1'b0;
                     end
                  end
               endcase
            end
         end

         WRITE: begin
            v_cea_d = 1'b1;
            v_ada_d = wr_addr;
            v_din_d = wr_data;
            ptr_d   = '0;
            state_d = wr_clr ? CLRROW : IDLE;
         end

         CLRROW: begin
            v_cea_d = 1'b1;
            v_ada_d = row_base + ptr;
            v_din_d = BLANK;
            ptr_d   = ptr + ADDR_W'(1);
            if (ptr == LAST_PTR) state_d = IDLE;
         end

         default: state_d = CLEAR;
      endcase
   end

   always_ff @(posedge MEMORY_CLK or negedge rst_n) begin
      if (!rst_n) begin
         state         <= CLEAR;
         ptr           <= '0;
         wr_addr       <= '0;
         wr_data       <= BLANK;
         wr_clr        <= 1'b0;
         clear_pending <= 1'b0;
         cursor_col    <= '0;
         cursor_row    <= '0;
         v_ada         <= '0;
         v_din         <= BLANK;
         v_cea         <= 1'b0;
         busy          <= 1'b1;
      end else begin
         // NOTE: non-blocking so every register samples the pre-edge values together.
         state         <= state_d;
         ptr           <= ptr_d;
         wr_addr       <= wr_addr_d;
         wr_data       <= wr_data_d;
         wr_clr        <= wr_clr_d;
         clear_pending <= clear_pending_d;
         cursor_col    <= col_d;
         cursor_row    <= row_d;
         v_ada         <= v_ada_d;
         v_din         <= v_din_d;
         v_cea         <= v_cea_d;
         busy          <= (state_d != IDLE);
      end
   end

endmodule
